// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, controller state encoding and the
// framebuffer address map for the 96x32 LED matrix driver.
package matrix_pkg;

  localparam int MATRIX_COLS = 96;
  localparam int MATRIX_ROWS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SWAP = 2'd2
  } matrix_state_t;

  // Framebuffer address map: {bank, x[7], y[4], y[3:0], x[6:0]}.
  // y[4] selects the hi/lo panel memory, so rows must be exactly 32.
  function automatic logic [13:0] matrix_wr_addr(input logic       bank,
                                                 input logic [7:0] x,
                                                 input logic [4:0] y);
    return {bank, x[7], y[4], y[3:0], x[6:0]};
  endfunction

endpackage

// File: rtl/matrix_sync2.sv
// matrix_sync2: two-flop synchroniser for a single level signal, reset to 0.
module matrix_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_fb_ctrl.sv
// matrix_fb_ctrl: framebuffer write-port arbiter between the host pixel
// stream and the fill engine, plus double-buffer swap sequencing.
// Optional macro MATRIX_AUTO_CLEAR_EN: every completed swap queues a
// black (12'h000) fill of the new back buffer.
//
// Host handshake: a pixel is transferred on a rising clk edge where
// px_valid && px_ready are both high; px_ready never depends on px_valid
// in the same cycle, and the write (or err_oob) appears the cycle after.
module matrix_fb_ctrl
  import matrix_pkg::*;
#(
  parameter int COLS = MATRIX_COLS,
  parameter int ROWS = MATRIX_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [6:0]  px_x,
  input  logic [4:0]  px_y,
  input  logic [11:0] px_rgb,
  input  logic        fill_start,
  input  logic [11:0] fill_rgb,
  output logic        fill_busy,
  input  logic        swap_req,
  output logic        swap_done,
  output logic        err_oob,
  output logic        wr,
  output logic [13:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        buffer_select,
  input  logic        buffer_current
);

  localparam logic [7:0] X_LIMIT = 8'(COLS);
  localparam logic [7:0] X_LAST  = 8'(COLS - 1);
  localparam logic [4:0] Y_LAST  = 5'(ROWS - 1);

  matrix_state_t state, state_n;
  logic          fill_pend, fill_pend_n;
  logic          swap_pend, swap_pend_n;
  logic [11:0]   fill_color, fill_color_n;
  logic [7:0]    fx, fx_n;
  logic [4:0]    fy, fy_n;
  logic          bsel_n;
  logic          wr_n;
  logic [13:0]   addr_n;
  logic [11:0]   data_n;
  logic          err_n;
  logic          ready_n;
  logic          bc_sync;
  logic          bb;
  logic          px_accept;

  matrix_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (buffer_current),
    .q   (bc_sync)
  );

  assign bb        = ~buffer_select;
  assign px_accept = px_valid && px_ready;
  assign fill_busy = (state == ST_FILL) || fill_pend;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      fill_pend     <= 1'b0;
      swap_pend     <= 1'b0;
      fill_color    <= 12'h000;
      fx            <= 8'd0;
      fy            <= 5'd0;
      buffer_select <= 1'b0;
      wr            <= 1'b0;
      wr_addr       <= 14'h0000;
      wr_data       <= 12'h000;
      err_oob       <= 1'b0;
      px_ready      <= 1'b0;
    end else begin
      state         <= state_n;
      fill_pend     <= fill_pend_n;
      swap_pend     <= swap_pend_n;
      fill_color    <= fill_color_n;
      fx            <= fx_n;
      fy            <= fy_n;
      buffer_select <= bsel_n;
      wr            <= wr_n;
      wr_addr       <= addr_n;
      wr_data       <= data_n;
      err_oob       <= err_n;
      px_ready      <= ready_n;
    end
  end

  // Next-state logic: host write > fill > swap when the port is contended.
  always_comb begin
    state_n      = state;
    fill_pend_n  = fill_pend;
    swap_pend_n  = swap_pend;
    fill_color_n = fill_color;
    fx_n         = fx;
    fy_n         = fy;
    bsel_n       = buffer_select;
    wr_n         = 1'b0;
    addr_n       = wr_addr;
    data_n       = wr_data;
    err_n        = 1'b0;
    swap_done    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fill_start) begin
          fill_pend_n  = 1'b1;
          fill_color_n = fill_rgb;
        end
        if (swap_req) swap_pend_n = 1'b1;

        if (px_accept) begin
          // A host pixel owns this cycle's write slot; a same-cycle fill
          // stays pending and starts on the next cycle.
          if ({1'b0, px_x} < X_LIMIT) begin
            wr_n   = 1'b1;
            addr_n = matrix_wr_addr(bb, {1'b0, px_x}, px_y);
            data_n = px_rgb;
          end else begin
            err_n = 1'b1;
          end
        end else if (fill_pend_n) begin
          // Pixel (0,0) is written on the first FILL cycle.
          state_n     = ST_FILL;
          fill_pend_n = 1'b0;
          fx_n        = 8'd0;
          fy_n        = 5'd0;
          wr_n        = 1'b1;
          addr_n      = matrix_wr_addr(bb, 8'd0, 5'd0);
          data_n      = fill_color_n;
        end

        // Swaps wait behind any fill; no port conflict with a host write.
        if (state_n == ST_IDLE && !fill_pend_n && swap_pend_n) begin
          bsel_n      = ~buffer_select;
          swap_pend_n = 1'b0;
          state_n     = ST_SWAP;
        end
      end

      ST_FILL: begin
        if (swap_req) swap_pend_n = 1'b1;
        // fx/fy hold the pixel on the port this cycle.
        if (fx == X_LAST && fy == Y_LAST) begin
          state_n = ST_IDLE;
        end else begin
          if (fx == X_LAST) begin
            fx_n = 8'd0;
            fy_n = fy + 5'd1;
          end else begin
            fx_n = fx + 8'd1;
          end
          wr_n   = 1'b1;
          addr_n = matrix_wr_addr(bb, fx_n, fy_n);
          data_n = fill_color;
        end
      end

      ST_SWAP: begin
        if (fill_start) begin
          fill_pend_n  = 1'b1;
          fill_color_n = fill_rgb;
        end
        if (bc_sync == buffer_select) begin
          swap_done = 1'b1;
          state_n   = ST_IDLE;
`ifdef MATRIX_AUTO_CLEAR_EN
          fill_pend_n  = 1'b1;
          fill_color_n = 12'h000;
`endif
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    ready_n = (state_n == ST_IDLE) && !swap_pend_n && !fill_pend_n;
  end

endmodule
